// File: rtl/muldiv_seq.sv
// Iterative RV64M multiply/divide unit: shift-add multiply and restoring divide, one bit per
// cycle on operand magnitudes, with the result sign applied when the result is written.
module muldiv_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [12:0]     op_sel,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  // Handshakes: a request transfers on a rising edge where in_valid & in_ready & !flush and
  // op_sel has at least one bit set; a result transfers where out_valid & out_ready & !flush.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [6:0]          cnt_q, cnt_d;
  logic [3:0]          op_q, op_d;
  logic                neg_q, neg_d, spec_q, spec_d;
  logic [2*XLEN-1:0]   acc_q, acc_d, mcand_q, mcand_d;
  logic [XLEN-1:0]     b_q, b_d, result_q, result_d;

  logic [3:0]          op_idx;
  logic                new_w, sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
  logic [XLEN-1:0]     a_ext, b_ext, a_mag, b_mag, spec_val;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo, rmd, fix_val;
  logic [XLEN:0]       shifted, diff;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction
  function automatic logic is_w(input logic [3:0] o);
    return o >= 4'd8;
  endfunction
  function automatic logic is_mul(input logic [3:0] o);
    return (o <= 4'd3) || (o == 4'd8);
  endfunction
  function automatic logic is_rem(input logic [3:0] o);
    return (o == 4'd6) || (o == 4'd7) || (o == 4'd11) || (o == 4'd12);
  endfunction
  function automatic logic signed_a(input logic [3:0] o);
    return o inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd8, 4'd9, 4'd11};
  endfunction
  function automatic logic signed_b(input logic [3:0] o);
    return o inside {4'd0, 4'd1, 4'd4, 4'd6, 4'd8, 4'd9, 4'd11};
  endfunction

  // Lowest set bit of op_sel selects the operation.
  always_comb begin
    op_idx = 4'd0;
    for (int i = 12; i >= 0; i--) begin
      if (op_sel[i]) op_idx = 4'(i);
    end
  end

  always_comb begin
    new_w = is_w(op_idx);
    sgn_a = signed_a(op_idx);
    sgn_b = signed_b(op_idx);
    if (new_w) begin
      a_ext = sgn_a ? sext32(src1[31:0]) : {{(XLEN-32){1'b0}}, src1[31:0]};
      b_ext = sgn_b ? sext32(src2[31:0]) : {{(XLEN-32){1'b0}}, src2[31:0]};
    end else begin
      a_ext = src1;
      b_ext = src2;
    end
    neg_a    = sgn_a & a_ext[XLEN-1];
    neg_b    = sgn_b & b_ext[XLEN-1];
    a_mag    = neg_a ? -a_ext : a_ext;
    b_mag    = neg_b ? -b_ext : b_ext;
    div_zero = !is_mul(op_idx) && (b_ext == '0);
    div_ovf  = !is_mul(op_idx) && sgn_a && (b_ext == '1) &&
               (new_w ? (a_ext[31:0] == 32'h8000_0000) : (a_ext == {1'b1, {(XLEN-1){1'b0}}}));
    if (div_zero) spec_val = is_rem(op_idx) ? a_ext : '1;
    else          spec_val = is_rem(op_idx) ? '0 : a_ext;
  end

  always_comb begin
    prod    = neg_q ? -acc_q : acc_q;
    quo     = neg_q ? -b_q : b_q;
    rmd     = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    shifted = {acc_q[XLEN-1:0], b_q[XLEN-1]};
    diff    = shifted - {1'b0, mcand_q[XLEN-1:0]};
    if (spec_q) begin
      fix_val = b_q;
    end else if (is_mul(op_q)) begin
      case (op_q)
        4'd0:    fix_val = prod[XLEN-1:0];
        4'd8:    fix_val = sext32(prod[31:0]);
        default: fix_val = prod[2*XLEN-1:XLEN];
      endcase
    end else begin
      fix_val = is_rem(op_q) ? rmd : quo;
      if (is_w(op_q)) fix_val = sext32(fix_val[31:0]);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    spec_d   = spec_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    b_d      = b_q;
    result_d = result_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && (|op_sel)) begin
            state_d = S_CALC;
            op_d    = op_idx;
            neg_d   = is_rem(op_idx) ? neg_a : (neg_a ^ neg_b);
            acc_d   = '0;
            // Special cases park their answer in b and spend one CALC cycle with a zero count.
            spec_d  = div_zero || div_ovf;
            if (div_zero || div_ovf) begin
              cnt_d = 7'd0;
              b_d   = new_w ? sext32(spec_val[31:0]) : spec_val;
            end else begin
              cnt_d = new_w ? 7'd32 : 7'(XLEN);
              if (is_mul(op_idx)) begin
                mcand_d = {{XLEN{1'b0}}, a_mag};
                b_d     = b_mag;
              end else begin
                mcand_d = {{XLEN{1'b0}}, b_mag};
                b_d     = new_w ? {a_mag[31:0], {(XLEN-32){1'b0}}} : a_mag;
              end
            end
          end
        end
        S_CALC: begin
          if (cnt_q == 7'd0) begin
            state_d  = S_DONE;
            result_d = fix_val;
          end else begin
            cnt_d = cnt_q - 7'd1;
            if (is_mul(op_q)) begin
              if (b_q[0]) acc_d = acc_q + mcand_q;
              mcand_d = mcand_q << 1;
              b_d     = b_q >> 1;
            end else if (!diff[XLEN]) begin
              acc_d = {{XLEN{1'b0}}, diff[XLEN-1:0]};
              b_d   = {b_q[XLEN-2:0], 1'b1};
            end else begin
              acc_d = {{XLEN{1'b0}}, shifted[XLEN-1:0]};
              b_d   = {b_q[XLEN-2:0], 1'b0};
            end
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      spec_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      spec_q   <= spec_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV64M vectors, special cases, flush/reset,
// back-pressure and a randomized back-to-back run against a reference model.
module tb_muldiv_seq;
  localparam int XLEN = 64;
  localparam logic [12:0] OP_MUL = 13'h0001, OP_MULH = 13'h0002, OP_MULHSU = 13'h0004;
  localparam logic [12:0] OP_MULHU = 13'h0008, OP_DIV = 13'h0010, OP_DIVU = 13'h0020;
  localparam logic [12:0] OP_REM = 13'h0040, OP_REMU = 13'h0080, OP_MULW = 13'h0100;
  localparam logic [12:0] OP_DIVW = 13'h0200, OP_DIVUW = 13'h0400, OP_REMW = 13'h0800;
  localparam logic [12:0] OP_REMUW = 13'h1000;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  typedef struct {
    logic [12:0] op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] e;
    int          lat;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst, in_valid, flush, out_ready;
  logic            in_ready, out_valid, busy;
  logic [12:0]     op_sel;
  logic [XLEN-1:0] src1, src2, result;
  logic [1:0]      dbg_state;
  int              total = 0;
  int              bad = 0;
  logic [63:0]     exp_q[$];

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel),
    .src1(src1), .src2(src2), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_model(input int idx, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa, pb, pp;
    logic signed [63:0]  sa, sb, sq;
    logic signed [31:0]  wa, wb, wq;
    logic [31:0]         ua, ub, w;
    logic [63:0]         r;
    sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
    r = '0; w = '0; pp = '0;
    case (idx)
      0, 1, 2, 3: begin
        pa = (idx == 3) ? {64'd0, a} : {{64{a[63]}}, a};
        pb = (idx >= 2) ? {64'd0, b} : {{64{b[63]}}, b};
        pp = pa * pb;
        r = (idx == 0) ? pp[63:0] : pp[127:64];
      end
      4: begin
        if (b == 0) r = '1;
        else if (a == MIN64 && b == '1) r = a;
        else begin sq = sa / sb; r = sq; end
      end
      5: r = (b == 0) ? '1 : a / b;
      6: begin
        if (b == 0) r = a;
        else if (a == MIN64 && b == '1) r = '0;
        else begin sq = sa % sb; r = sq; end
      end
      7: r = (b == 0) ? a : a % b;
      8: w = ua * ub;
      9: begin
        if (ub == 0) w = '1;
        else if (ua == 32'h8000_0000 && ub == '1) w = ua;
        else begin wq = wa / wb; w = wq; end
      end
      10: w = (ub == 0) ? '1 : ua / ub;
      11: begin
        if (ub == 0) w = ua;
        else if (ua == 32'h8000_0000 && ub == '1) w = '0;
        else begin wq = wa % wb; w = wq; end
      end
      default: w = (ub == 0) ? ua : ua % ub;
    endcase
    if (idx >= 8) r = {{32{w[31]}}, w};
    return r;
  endfunction

  function automatic int ref_lat(input int idx, input logic [63:0] a, input logic [63:0] b);
    logic is_div, sgn;
    is_div = !(idx <= 3 || idx == 8);
    sgn = (idx == 4 || idx == 6 || idx == 9 || idx == 11);
    if (is_div && idx < 8 && (b == 0 || (sgn && a == MIN64 && b == '1))) return 1;
    if (is_div && idx >= 8 && (b[31:0] == 0 || (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == '1)))
      return 1;
    return (idx >= 8) ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return '1;
      2: return MIN64;
      3: return {$urandom, 32'h8000_0000};
      4: return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Issues one request, records its expected result, and returns the observed result together
  // with the number of rising edges from the accept edge to the first edge showing out_valid.
  task automatic do_op(input logic [12:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, output logic [63:0] res, output int lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1; op_sel = op; src1 = a; src2 = b;
    exp_q.push_back(exp);
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_sel = 13'($urandom);
    src1 = {$urandom, $urandom};
    src2 = {$urandom, $urandom};
    lat = 0;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    res = result;
  endtask

  task automatic start_op(input logic [12:0] op, input logic [63:0] a, input logic [63:0] b);
    int n;
    @(negedge clk);
    in_valid = 1'b1; op_sel = op; src1 = a; src2 = b;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; op_sel = OP_MUL; src1 = 64'd3; src2 = 64'd4;
    flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b exp=0", busy); end
    total++; if (result !== 64'd0) begin bad++; $display("FAIL reset result got=%h exp=0", result); end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_mul();
    vec_t v[4];
    logic [63:0] res, e;
    int lat;
    v[0] = '{OP_MUL, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    v[1] = '{OP_MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    v[2] = '{OP_MULH, '1, '1, 64'h0, 65};
    v[3] = '{OP_MULHSU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    for (int i = 0; i < 4; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, v[i].e, res, lat);
      e = exp_q.pop_front();
      total++; if (res !== e) begin bad++; $display("FAIL mul[%0d] result got=%h exp=%h", i, res, e); end
      total++; if (lat !== v[i].lat) begin bad++; $display("FAIL mul[%0d] latency got=%0d exp=%0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_div();
    vec_t v[8];
    logic [63:0] res, e;
    int lat;
    v[0] = '{OP_DIV, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
    v[1] = '{OP_REM, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};
    v[2] = '{OP_DIVU, 64'd100, 64'd7, 64'd14, 65};
    v[3] = '{OP_REMU, 64'd100, 64'd7, 64'd2, 65};
    v[4] = '{OP_DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    v[5] = '{OP_REMU, 64'd5, 64'd0, 64'd5, 1};
    v[6] = '{OP_DIV, MIN64, '1, MIN64, 1};
    v[7] = '{OP_REM, MIN64, '1, 64'd0, 1};
    for (int i = 0; i < 8; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, v[i].e, res, lat);
      e = exp_q.pop_front();
      total++; if (res !== e) begin bad++; $display("FAIL div[%0d] result got=%h exp=%h", i, res, e); end
      total++; if (lat !== v[i].lat) begin bad++; $display("FAIL div[%0d] latency got=%0d exp=%0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_w_ops();
    vec_t v[6];
    logic [63:0] res, e;
    int lat;
    v[0] = '{OP_MULW, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33};
    v[1] = '{OP_DIVW, 64'h1_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1};
    v[2] = '{OP_DIVUW, 64'hDEAD_0000_FFFF_FFFF, 64'h5555_0000_0000_0001, '1, 33};
    v[3] = '{OP_REMW, 64'h1234_5678_FFFF_FFF9, 64'd2, '1, 33};
    v[4] = '{OP_REMUW, 64'hABCD_0000_8000_000A, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_000A, 1};
    v[5] = '{OP_DIVW, 64'd20, 64'h0000_0000_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 33};
    for (int i = 0; i < 6; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, v[i].e, res, lat);
      e = exp_q.pop_front();
      total++; if (res !== e) begin bad++; $display("FAIL w_op[%0d] result got=%h exp=%h", i, res, e); end
      total++; if (lat !== v[i].lat) begin bad++; $display("FAIL w_op[%0d] latency got=%0d exp=%0d", i, lat, v[i].lat); end
    end
  endtask

  task automatic test_op_select();
    logic [63:0] res, e;
    int lat;
    int seen_busy;
    do_op(OP_MULHU | OP_DIV | OP_REMUW, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, res, lat);
    e = exp_q.pop_front();
    total++; if (res !== e) begin bad++; $display("FAIL multi_hot result got=%h exp=%h", res, e); end
    total++; if (lat !== 65) begin bad++; $display("FAIL multi_hot latency got=%0d exp=65", lat); end
    @(negedge clk);
    in_valid = 1'b1; op_sel = 13'd0; src1 = 64'd9; src2 = 64'd3;
    seen_busy = 0;
    repeat (4) begin @(posedge clk); #1; if (busy) seen_busy++; end
    total++; if (seen_busy !== 0) begin bad++; $display("FAIL zero_op busy_cycles got=%0d exp=0", seen_busy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL zero_op in_ready got=%b exp=1", in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    int seen;
    logic [63:0] res, e;
    int lat;
    start_op(OP_MUL, 64'd123, 64'd456);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_calc in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_calc out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_calc busy got=%b exp=0", busy); end
    seen = 0;
    repeat (80) begin @(posedge clk); #1; if (out_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL flush_calc late_out_valid got=%0d exp=0", seen); end
    @(negedge clk);
    in_valid = 1'b1; op_sel = OP_DIV; src1 = 64'd10; src2 = 64'd2; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle busy got=%b exp=0", busy); end
    out_ready = 1'b0;
    do_op(OP_DIVU, 64'd50, 64'd5, 64'd10, res, lat);
    e = exp_q.pop_front();
    total++; if (res !== e) begin bad++; $display("FAIL flush_done result got=%h exp=%h", res, e); end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; out_ready = 1'b1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_done out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_done in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_backpressure();
    logic [63:0] res, e;
    int lat;
    int unstable;
    out_ready = 1'b0;
    do_op(OP_REM, 64'd1000, 64'd7, 64'd6, res, lat);
    e = exp_q.pop_front();
    total++; if (res !== e) begin bad++; $display("FAIL hold result got=%h exp=%h", res, e); end
    unstable = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || result !== e) unstable++;
    end
    total++; if (unstable !== 0) begin bad++; $display("FAIL hold unstable_cycles got=%0d exp=0", unstable); end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold release out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid_op();
    start_op(OP_DIV, 64'd77, 64'd5);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (result !== 64'd0) begin bad++; $display("FAIL mid_reset result got=%h exp=0", result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset busy got=%b exp=0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a, b, res, e;
    logic [12:0] oh;
    int idx, lat, elat;
    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(0, 12);
      a = pick_operand();
      b = pick_operand();
      oh = (13'd1 << idx) | (13'($urandom) & ~((13'd2 << idx) - 13'd1));
      elat = ref_lat(idx, a, b);
      do_op(oh, a, b, ref_model(idx, a, b), res, lat);
      e = exp_q.pop_front();
      total++; if (res !== e) begin bad++; $display("FAIL rand[%0d] op=%0d a=%h b=%h got=%h exp=%h", i, idx, a, b, res, e); end
      total++; if (lat !== elat) begin bad++; $display("FAIL rand[%0d] op=%0d latency got=%0d exp=%0d", i, idx, lat, elat); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mul();
    test_div();
    test_w_ops();
    test_op_select();
    test_flush();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard leftover got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
